// File: rtl/controller_pkg.sv
// Shared field positions for the controller status word and a width helper.
// Used by controller_input and btn_debounce.
package controller_pkg;

  localparam int LEVEL_LSB   = 0;
  localparam int EVENT_LSB   = 16;
  localparam int PENDING_BIT = 31;
  localparam int MAX_BTN     = 16;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    while ((longint'(1) << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, debounce counter, rise strobe, optional repeat (CONTROLLER_AUTOREPEAT_EN).
// Level/strobe appear DEBOUNCE_CYCLES+1 edges after a raw change is sampled; no backpressure.
module btn_debounce
  import controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             accept, rise, fall, rpt_fire;

  always_comb begin
    accept   = (sync_q != stable_q) && (cnt_q == CNT_LAST);
    rise     = accept && sync_q;
    fall     = accept && !sync_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (accept) stable_d = sync_q;
    else if (sync_q != stable_q) cnt_d = cnt_q + CNT_W'(1);
    press_d  = rise | rpt_fire;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      meta_q   <= btn_raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

`ifdef CONTROLLER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = clog2(longint'(RPT_MAX) + 1);

  // rpt_cnt_q counts edges since the last strobe; first_q selects the initial delay.
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;

  always_comb begin
    rpt_fire    = 1'b0;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    if (rise) begin
      rpt_cnt_d   = RPT_W'(1);
      rpt_first_d = 1'b1;
    end else if (!stable_q || fall) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b0;
    end else if (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD))) begin
      rpt_fire    = 1'b1;
      rpt_cnt_d   = RPT_W'(1);
      rpt_first_d = 1'b0;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/controller_input.sv
// Debounced button levels plus sticky press events packed into the processor's controller word.
// Levels/strobes DEBOUNCE_CYCLES+1 edges after a raw change, events one edge later; optional CONTROLLER_AUTOREPEAT_EN.
module controller_input
  import controller_pkg::*;
#(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             event_ack,
  output logic [31:0]      controller,
  output logic [N_BTN-1:0] press_pulse
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] event_q, event_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_btn (
      .clock     (clock),
      .reset     (reset),
      .btn_raw_i (btn_raw[g]),
      .level_o   (level[g]),
      .press_o   (press_pulse[g])
    );
  end

  // A press landing with the ack survives; the ack only clears older events.
  assign event_d = (event_ack ? '0 : event_q) | press_pulse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) event_q <= '0;
    else        event_q <= event_d;
  end

  always_comb begin
    controller                     = '0;
    controller[LEVEL_LSB +: N_BTN] = level;
    controller[EVENT_LSB +: N_BTN] = event_q;
    controller[PENDING_BIT]        = |event_q;
  end

endmodule

// File: doc/controller_input.md
# controller_input

Conditions the game controller's raw button lines into the 32-bit `controller` word the processor reads as its controller input. It sits directly upstream of the processor. Per button it:
- synchronizes the raw line to `clock`;
- debounces it with a per-button counter;
- detects presses and holds them as sticky event bits until the processor acknowledges them.

The processor therefore sees clean levels and never misses a short press between polls.

## Interface
- `N_BTN`, 8: number of buttons, legal range 1–16.
- `DEBOUNCE_CYCLES`, 250000: number of consecutive stable cycles needed to accept a new level (5 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, 25000000: cycles from a press to the first auto-repeat. Used only with `CONTROLLER_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 5000000: cycles between later auto-repeats. Used only with `CONTROLLER_AUTOREPEAT_EN`.
- `clock`  in  1  system clock; all flops rise-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  N_BTN  raw, asynchronous button lines; 1 = pressed.
- `event_ack`  in  1  one-cycle pulse from the processor side that clears all sticky event bits.
- `controller`  out  32  status word read by the processor:
  - `[N_BTN-1:0]` debounced levels;
  - `[16+N_BTN-1:16]` sticky press events;
  - `[31]` OR of all event bits;
  - all other bits 0.
- `press_pulse`  out  N_BTN  one-cycle strobe per accepted press, or per repeat when repeat is enabled.

## Operation
- **Synchronizer:** two flops per line; `sync` is the second flop.
- **Debounce, per button:** counter `cnt` of width clog2(DEBOUNCE_CYCLES) and register `stable`.
  - While `sync == stable`: `cnt` is held at 0.
  - While `sync != stable`: `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and `sync != stable`: `stable` takes `sync` and `cnt` returns to 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles returns `cnt` to 0 and changes nothing.
- **Press detect:** a `stable` transition 0→1 raises `press_pulse[i]` for exactly one cycle and sets `event[i]`. A release (1→0) produces no event.
- **Events:**
  - `event_ack` clears every `event` bit.
  - If a set and `event_ack` land in the same cycle, the set wins for that bit; all other bits clear.
  - `controller[31]` is combinational from the event register.
- **Reset (async assert, sync release):** all flops go to 0.
  - `controller` = 0 and `press_pulse` = 0.
  - A reset in mid-debounce discards the count.
  - A button held through reset produces a press event `DEBOUNCE_CYCLES+2` cycles after release.

## Timing
- A raw change sampled at edge k updates `stable` and `controller` at edge k+1+DEBOUNCE_CYCLES. `press_pulse` is asserted in that same cycle.
- `event[i]` is visible in `controller[16+i]` in the cycle after `press_pulse[i]`.
- `event_ack` sampled at edge k clears the event bits at edge k. The cleared word is visible from cycle k+1.
- `controller` is fully registered except bit 31, which is one OR level.

## Configuration
- `CONTROLLER_AUTOREPEAT_EN` defined, per button:
  - a repeat counter starts when a press is accepted;
  - after `REPEAT_DELAY` cycles of continuous `stable == 1`, and then every `REPEAT_PERIOD` cycles, it pulses `press_pulse[i]` and sets `event[i]`;
  - release, or `reset` going low, clears the counter.
- Macro undefined: there is no repeat logic, the repeat parameters are ignored, and a hold produces exactly one event.

## Structure
- `controller_pkg` holds:
  - `LEVEL_LSB = 0`, `EVENT_LSB = 16`, `PENDING_BIT = 31`, `MAX_BTN = 16`;
  - the clog2 helper for counter widths.
- Sub-module `btn_debounce` handles one button: synchronizer, debounce counter, `stable`, rise strobe, and the optional repeat counter.
- The top level instantiates N_BTN copies of `btn_debounce` in a generate loop. It owns the event register, the ack logic and `controller` packing.

## Test plan
Run with `N_BTN=4` and `DEBOUNCE_CYCLES=4`.
- **Reset:** `reset` low mid-run → `controller` = 0x00000000 and `press_pulse` = 0 immediately, with no clock edge needed.
- **Clean press:** `btn_raw[2]` 0→1 sampled at edge 10 → bit 2 of `controller` and `press_pulse[2]` go high at edge 15; `controller` = 0x80040004 from edge 16.
- **Glitch reject:** `btn_raw[0]` high for 3 cycles then low → `controller` stays 0 and no pulse occurs.
- **Ack:** after `controller` = 0x80040004, `event_ack` pulse → 0x00000004 while the button is still held.
- **Set/ack collision:** `event[1]` already set, `btn_raw[3]` press accepted in the same cycle as `event_ack` → the next cycle shows bit 19 set, bit 17 clear, bit 31 set.
- **Auto-repeat** (macro defined, `REPEAT_DELAY=8`, `REPEAT_PERIOD=4`): hold `btn_raw[1]` → `press_pulse[1]` at press acceptance, then 8 cycles later, then every 4 cycles until release.
